// File: rtl/sram_controller_if.sv
// MEM-stage data-memory bus between the pipeline (master) and the SRAM controller (slave).
// Handshake: a request (MEM_r_en or MEM_w_en) is held stable while ready=0; the
// transfer completes in the single cycle where ready returns to 1, and r_data is valid then.
interface sram_controller_if;
  logic        MEM_r_en;
  logic        MEM_w_en;
  logic [31:0] address;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        ready;

  modport master (
    output MEM_r_en, MEM_w_en, address, w_data,
    input  r_data, ready
  );

  modport slave (
    input  MEM_r_en, MEM_w_en, address, w_data,
    output r_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Word-wide MEM-stage data memory backed by a 16-bit asynchronous SRAM:
// every word access is split into a low-half then a high-half phase.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       bus,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int CW = $clog2(WAIT_CYCLES);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   dq_oe;
  logic [15:0]            dq_out;
  logic [31:0]            offs;
  logic [SRAM_ADDR_W-1:0] addr_lo;
  logic [SRAM_ADDR_W-1:0] addr_hi;
  logic                   last;
  logic                   pre_last;
  logic                   unused_offs;

  // Address arithmetic wraps mod 2^32; out-of-range words simply alias.
  assign offs        = bus.address - 32'(BASE_ADDR);
  assign addr_lo     = {offs[SRAM_ADDR_W:2], 1'b0};
  assign addr_hi     = {SRAM_ADDR[SRAM_ADDR_W-1:1], 1'b1};
  assign unused_offs = ^{offs[31:SRAM_ADDR_W+1], offs[1:0]};

  assign last     = (cnt == CW'(WAIT_CYCLES - 1));
  assign pre_last = (cnt == CW'(WAIT_CYCLES - 2));

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign dbg_state = state;

  // In IDLE a pending request drops ready in the same cycle so the pipeline freezes at once.
  assign bus.ready = (state == IDLE) ? ~(bus.MEM_r_en | bus.MEM_w_en) : (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bus.r_data <= '0;
      SRAM_WE_N  <= 1'b1;
      SRAM_ADDR  <= '0;
      dq_oe      <= 1'b0;
      dq_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.MEM_w_en) begin
            state     <= WR_LO;
            SRAM_ADDR <= addr_lo;
            dq_out    <= bus.w_data[15:0];
            dq_oe     <= 1'b1;
            SRAM_WE_N <= 1'b0;
          end else if (bus.MEM_r_en) begin
            state     <= RD_LO;
            SRAM_ADDR <= addr_lo;
          end
        end
        RD_LO: begin
          if (last) begin
            bus.r_data[15:0] <= SRAM_DQ;
            state            <= RD_HI;
            cnt              <= '0;
            SRAM_ADDR        <= addr_hi;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_HI: begin
          if (last) begin
            bus.r_data[31:16] <= SRAM_DQ;
            state             <= DONE;
            cnt               <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // WE_N rises for the final cycle of each half so address and data are held past the strobe.
        WR_LO: begin
          if (last) begin
            state     <= WR_HI;
            cnt       <= '0;
            SRAM_ADDR <= addr_hi;
            dq_out    <= bus.w_data[31:16];
            SRAM_WE_N <= 1'b0;
          end else begin
            cnt       <= cnt + 1'b1;
            SRAM_WE_N <= pre_last;
          end
        end
        WR_HI: begin
          if (last) begin
            state     <= DONE;
            cnt       <= '0;
            dq_oe     <= 1'b0;
            SRAM_WE_N <= 1'b1;
          end else begin
            cnt       <= cnt + 1'b1;
            SRAM_WE_N <= pre_last;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          dq_oe     <= 1'b0;
          SRAM_WE_N <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed word reads/writes against a small SRAM model,
// with r_data checked by a scoreboard whenever ready rises after an access.
module tb_sram_controller;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT with default timing ----------------
  sram_controller_if bus ();
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;
  logic [2:0]  dbg_state;
  logic        sram_drive = 1'b0;
  logic [15:0] mem [0:63];

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .SRAM_CE_N(sram_ce_n),
    .SRAM_OE_N(sram_oe_n), .dbg_state(dbg_state)
  );

  // SRAM model: drives read data when the bench says a read is active, latches on WE_N rising.
  assign sram_dq = sram_drive ? mem[sram_addr[5:0]] : 16'hzzzz;
  always @(posedge sram_we_n) begin
    if (!rst) mem[sram_addr[5:0]] <= sram_dq;
  end

  // ---------------- DUT with WAIT_CYCLES=4 ----------------
  sram_controller_if bus4 ();
  wire  [15:0] sram_dq4;
  logic [17:0] sram_addr4;
  logic        we_n4, ub_n4, lb_n4, ce_n4, oe_n4;
  logic [2:0]  dbg_state4;
  logic        drive4 = 1'b0;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(4), .SRAM_ADDR_W(18)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave),
    .SRAM_DQ(sram_dq4), .SRAM_ADDR(sram_addr4), .SRAM_WE_N(we_n4),
    .SRAM_UB_N(ub_n4), .SRAM_LB_N(lb_n4), .SRAM_CE_N(ce_n4),
    .SRAM_OE_N(oe_n4), .dbg_state(dbg_state4)
  );
  assign sram_dq4 = drive4 ? 16'h5A5A : 16'hzzzz;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;
  logic        prev_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of ready after an access is one completed transfer.
  always @(negedge clk) begin
    if (rst) begin
      prev_ready <= 1'b1;
    end else begin
      if (bus.ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow: got r_data %h expected no transfer", bus.r_data);
        end else begin
          exp_v = exp_q.pop_front();
          check("r_data", bus.r_data, exp_v);
        end
      end
      prev_ready <= bus.ready;
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_r, input logic [17:0] exp_a,
                       input logic [4:0] exp_we);
    int          n;
    bit          done;
    logic [4:0]  pat;
    logic [17:0] a_lo, a_hi;
    n = 0; done = 0; pat = '0; a_lo = '0; a_hi = '0;
    @(posedge clk); #1;
    bus.address  = addr;
    bus.w_data   = wdata;
    bus.MEM_w_en = wr;
    bus.MEM_r_en = !wr;
    sram_drive   = !wr;
    exp_q.push_back(exp_r);
    while (!done && n < 50) begin
      @(negedge clk);
      if (bus.ready) begin
        done = 1;
      end else begin
        pat = {pat[3:0], sram_we_n};
        if (n == 1)     a_lo = sram_addr;
        if (n == W + 1) a_hi = sram_addr;
        n++;
      end
    end
    bus.MEM_w_en = 1'b0;
    bus.MEM_r_en = 1'b0;
    sram_drive   = 1'b0;
    check("busy_cycles", n, 2 * W + 1);
    check("we_n_shape", {27'd0, pat}, {27'd0, exp_we});
    check("addr_lo", {14'd0, a_lo}, {14'd0, exp_a});
    check("addr_hi", {14'd0, a_hi}, {14'd0, exp_a | 18'd1});
  endtask

  int n4;
  bit d4;

  initial begin
    bus.MEM_r_en = 0; bus.MEM_w_en = 0; bus.address = 0; bus.w_data = 0;
    bus4.MEM_r_en = 0; bus4.MEM_w_en = 0; bus4.address = 0; bus4.w_data = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    mem[0] = 16'h2222;
    mem[1] = 16'h1111;

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_r_data", bus.r_data, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    rst = 1'b0;

    // Idle: nothing moves for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle", {27'd0, bus.ready, sram_we_n, dbg_state}, {27'd0, 1'b1, 1'b1, 3'd0});
    end

    // Back-to-back read / write / read.
    do_op(0, 32'd1024, 32'd0,          32'h11112222, 18'd0, 5'b11111);
    do_op(1, 32'd1028, 32'h33334444,   32'h11112222, 18'd2, 5'b10101);
    do_op(0, 32'd1028, 32'd0,          32'h33334444, 18'd2, 5'b11111);

    // Write then read, including ignored low address bits.
    do_op(1, 32'd1032, 32'hDEADBEEF,   32'h33334444, 18'd4, 5'b10101);
    check("mem_lo", {16'd0, mem[4]}, 32'h0000BEEF);
    check("mem_hi", {16'd0, mem[5]}, 32'h0000DEAD);
    do_op(0, 32'd1032, 32'd0,          32'hDEADBEEF, 18'd4, 5'b11111);
    do_op(0, 32'd1035, 32'd0,          32'hDEADBEEF, 18'd4, 5'b11111);

    // Address below BASE_ADDR wraps: (0-1024)[18:2] = 0x1FF00.
    do_op(0, 32'd0, 32'd0,             32'h11112222, 18'h3FE00, 5'b11111);

    // Reset in the middle of WR_HI.
    @(posedge clk); #1;
    bus.address = 32'd1040; bus.w_data = 32'h77778888; bus.MEM_w_en = 1'b1;
    repeat (4) @(negedge clk);
    check("wr_hi_strobe", {29'd0, dbg_state, sram_we_n}, {28'd0, 3'd4, 1'b0});
    rst = 1'b1;
    bus.MEM_w_en = 1'b0;
    #1;
    check("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("midrst_r_data", bus.r_data, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", {30'd0, bus.ready, dbg_state == 3'd0}, 32'd3);
    do_op(0, 32'd1024, 32'd0,          32'h11112222, 18'd0, 5'b11111);

    // WAIT_CYCLES=4 instance: nine busy cycles for one read.
    @(posedge clk); #1;
    bus4.address = 32'd1024; bus4.MEM_r_en = 1'b1; drive4 = 1'b1;
    n4 = 0; d4 = 0;
    while (!d4 && n4 < 50) begin
      @(negedge clk);
      if (bus4.ready) d4 = 1;
      else n4++;
    end
    bus4.MEM_r_en = 1'b0; drive4 = 1'b0;
    check("busy_cycles_w4", n4, 9);
    check("r_data_w4", bus4.r_data, 32'h5A5A5A5A);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
